// File: rtl/decode_stage_if.sv
// Bundle of fetch-side, register-file, writeback and ALU-side signals around the decode stage.
// The slave modport is the decode stage itself; master is whatever surrounds it.
interface decode_stage_if;
    logic        instValid;
    logic [31:0] instData;
    logic [31:0] pcIn;
    logic        instReady;
    logic [4:0]  readAddrF;
    logic [4:0]  readAddrS;
    logic [31:0] outDataF;
    logic [31:0] outDataS;
    logic        wbEnable;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        flush;
    logic        aluValid;
    logic        aluReady;
    logic [3:0]  aluOp;
    logic [31:0] aluSrcF;
    logic [31:0] aluSrcS;
    logic [31:0] aluImm;
    logic        aluUseImm;
    logic [4:0]  aluRd;
    logic        aluRegWrite;
    logic [31:0] aluPc;
    logic        aluIllegal;

    modport slave (
        input  instValid, instData, pcIn, outDataF, outDataS,
        input  wbEnable, wbAddr, wbData, flush, aluReady,
        output instReady, readAddrF, readAddrS,
        output aluValid, aluOp, aluSrcF, aluSrcS, aluImm, aluUseImm,
        output aluRd, aluRegWrite, aluPc, aluIllegal
    );

    modport master (
        output instValid, instData, pcIn, outDataF, outDataS,
        output wbEnable, wbAddr, wbData, flush, aluReady,
        input  instReady, readAddrF, readAddrS,
        input  aluValid, aluOp, aluSrcF, aluSrcS, aluImm, aluUseImm,
        input  aluRd, aluRegWrite, aluPc, aluIllegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes one instruction per cycle, reads operands with WB bypass,
// and tracks in-flight destinations in a pending scoreboard to stall RAW/WAW hazards.
module decode_stage (
    input  logic           clk,
    input  logic           resetIn,
    decode_stage_if.slave  bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR = 4'd8,   ALU_AND = 4'd9, ALU_PASSB = 4'd10;

    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] pick_operand(input logic [4:0] rs, input logic [31:0] rf,
                                                 input logic wb_en, input logic [4:0] wb_addr,
                                                 input logic [31:0] wb_data);
        logic [31:0] v;
        if (rs == 5'd0) begin
            v = 32'd0;
        end else if (wb_en && (wb_addr == rs)) begin
            v = wb_data;
        end else begin
            v = rf;
        end
        return v;
    endfunction

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign inst   = bus.instData;
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'd0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    assign bus.readAddrF = rs1;
    assign bus.readAddrS = rs2;

    logic [3:0]  dec_op;
    logic [31:0] dec_imm;
    logic        dec_use_imm, dec_write, dec_illegal, dec_rs1, dec_rs2;

    // Opcode decode; illegal opcodes read no operands so they never stall.
    always_comb begin
        dec_op      = ALU_ADD;
        dec_imm     = 32'd0;
        dec_use_imm = 1'b0;
        dec_write   = 1'b0;
        dec_illegal = 1'b0;
        dec_rs1     = 1'b0;
        dec_rs2     = 1'b0;
        case (opcode)
            OPC_LUI:    begin dec_op = ALU_PASSB; dec_imm = imm_u; dec_use_imm = 1'b1; dec_write = 1'b1; end
            OPC_AUIPC:  begin dec_imm = imm_u; dec_use_imm = 1'b1; dec_write = 1'b1; end
            OPC_JAL:    begin dec_imm = imm_j; dec_use_imm = 1'b1; dec_write = 1'b1; end
            OPC_JALR:   begin dec_imm = imm_i; dec_use_imm = 1'b1; dec_write = 1'b1; dec_rs1 = 1'b1; end
            OPC_BRANCH: begin
                case (funct3[2:1])
                    2'b10:   dec_op = ALU_SLT;
                    2'b11:   dec_op = ALU_SLTU;
                    default: dec_op = ALU_SUB;
                endcase
                dec_imm = imm_b;
                dec_rs1 = 1'b1;
                dec_rs2 = 1'b1;
            end
            OPC_LOAD:   begin dec_imm = imm_i; dec_use_imm = 1'b1; dec_write = 1'b1; dec_rs1 = 1'b1; end
            OPC_STORE:  begin dec_imm = imm_s; dec_use_imm = 1'b1; dec_rs1 = 1'b1; dec_rs2 = 1'b1; end
            OPC_OPIMM:  begin
                dec_op      = alu_sel(funct3, inst[30] & (funct3 == 3'b101));
                dec_imm     = imm_i;
                dec_use_imm = 1'b1;
                dec_write   = 1'b1;
                dec_rs1     = 1'b1;
            end
            OPC_OP:     begin
                dec_op    = alu_sel(funct3, inst[30]);
                dec_write = 1'b1;
                dec_rs1   = 1'b1;
                dec_rs2   = 1'b1;
            end
            default:    dec_illegal = 1'b1;
        endcase
    end

    logic        reg_write, use_rs1, use_rs2, hazard, accept;
    logic [31:0] pending_q, pending_d, clr_wb, clr_flush, set_acc;
    logic        valid_q, use_imm_q, reg_write_q, illegal_q;
    logic [3:0]  op_q;
    logic [4:0]  rd_q;
    logic [31:0] src_f_q, src_s_q, imm_q, pc_q;

    assign reg_write = dec_write & (rd != 5'd0);
    assign use_rs1   = dec_rs1 & (rs1 != 5'd0);
    assign use_rs2   = dec_rs2 & (rs2 != 5'd0);
    // A WB in this very cycle resolves a RAW (operand comes through the bypass).
    assign hazard = (use_rs1 & pending_q[rs1] & ~(bus.wbEnable & (bus.wbAddr == rs1)))
                  | (use_rs2 & pending_q[rs2] & ~(bus.wbEnable & (bus.wbAddr == rs2)))
                  | (reg_write & pending_q[rd]);

    assign bus.instReady = ~resetIn & ~bus.flush & ~hazard & (~valid_q | bus.aluReady);
    assign accept        = bus.instValid & bus.instReady;

    // Set is applied after both clears so a same-cycle set wins; x0 is never pending.
    assign clr_wb    = bus.wbEnable ? (32'd1 << bus.wbAddr) : 32'd0;
    assign clr_flush = (bus.flush & valid_q & reg_write_q) ? (32'd1 << rd_q) : 32'd0;
    assign set_acc   = (accept & reg_write) ? (32'd1 << rd) : 32'd0;
    assign pending_d = ((pending_q & ~clr_wb & ~clr_flush) | set_acc) & ~32'd1;

    // Scoreboard and Dec_ALU pipeline register.
    always_ff @(posedge clk or posedge resetIn) begin
        if (resetIn) begin
            pending_q   <= 32'd0;
            valid_q     <= 1'b0;
            op_q        <= 4'd0;
            src_f_q     <= 32'd0;
            src_s_q     <= 32'd0;
            imm_q       <= 32'd0;
            use_imm_q   <= 1'b0;
            rd_q        <= 5'd0;
            reg_write_q <= 1'b0;
            pc_q        <= 32'd0;
            illegal_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (accept) begin
                valid_q     <= 1'b1;
                op_q        <= dec_op;
                src_f_q     <= pick_operand(rs1, bus.outDataF, bus.wbEnable, bus.wbAddr, bus.wbData);
                src_s_q     <= pick_operand(rs2, bus.outDataS, bus.wbEnable, bus.wbAddr, bus.wbData);
                imm_q       <= dec_imm;
                use_imm_q   <= dec_use_imm;
                rd_q        <= rd;
                reg_write_q <= reg_write;
                pc_q        <= bus.pcIn;
                illegal_q   <= dec_illegal;
            end else if (bus.aluReady | bus.flush) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_q;
            end
        end
    end

    assign bus.aluValid    = valid_q;
    assign bus.aluOp       = op_q;
    assign bus.aluSrcF     = src_f_q;
    assign bus.aluSrcS     = src_s_q;
    assign bus.aluImm      = imm_q;
    assign bus.aluUseImm   = use_imm_q;
    assign bus.aluRd       = rd_q;
    assign bus.aluRegWrite = reg_write_q;
    assign bus.aluPc       = pc_q;
    assign bus.aluIllegal  = illegal_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed plus randomized bench for decode_stage, checked against an instruction-level
// model (format table, arithmetic immediates, per-register pending array).
module tb_decode_stage;
    logic clk;
    logic resetIn;
    decode_stage_if bus();

    decode_stage dut (.clk(clk), .resetIn(resetIn), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] imm;
        logic        use_imm;
        logic        wr;
        logic        ill;
        logic        use1;
        logic        use2;
    } dec_t;

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [31:0] imm;
        logic        use_imm;
        logic [4:0]  rd;
        logic        wr;
        logic        ill;
        logic [31:0] srcf;
        logic [31:0] srcs;
        logic [31:0] pc;
    } held_t;

    held_t       m_held;
    logic [31:0] m_pend;
    logic        sampled_ready;
    logic [31:0] pend_before;
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sext(input int v, input int w);
        int s;
        s = v <<< (32 - w);
        return s >>> (32 - w);
    endfunction

    function automatic dec_t model_decode(input logic [31:0] x);
        dec_t       d;
        logic [3:0] alu_map [8];
        int         f3;
        alu_map = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        d  = '{op: 4'd0, imm: 32'd0, use_imm: 1'b0, wr: 1'b0, ill: 1'b0, use1: 1'b0, use2: 1'b0};
        f3 = int'(x[14:12]);
        case (x[6:0])
            7'h37: begin d.op = 4'd10; d.imm = x & 32'hFFFFF000; d.use_imm = 1'b1; d.wr = 1'b1; end
            7'h17: begin d.imm = x & 32'hFFFFF000; d.use_imm = 1'b1; d.wr = 1'b1; end
            7'h6F: begin
                d.imm = sext(int'((((x >> 31) & 1) << 20) | (((x >> 12) & 255) << 12)
                             | (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1)), 21);
                d.use_imm = 1'b1; d.wr = 1'b1;
            end
            7'h67, 7'h03: begin d.imm = sext(int'(x >> 20), 12); d.use_imm = 1'b1; d.wr = 1'b1; d.use1 = 1'b1; end
            7'h63: begin
                d.op  = (f3 / 2 == 2) ? 4'd3 : (f3 / 2 == 3) ? 4'd4 : 4'd1;
                d.imm = sext(int'((((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11)
                             | (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1)), 13);
                d.use1 = 1'b1; d.use2 = 1'b1;
            end
            7'h23: begin
                d.imm = sext(int'(((x >> 25) << 5) | ((x >> 7) & 31)), 12);
                d.use_imm = 1'b1; d.use1 = 1'b1; d.use2 = 1'b1;
            end
            7'h13: begin
                d.op = (f3 == 5 && x[30]) ? 4'd7 : alu_map[f3];
                d.imm = sext(int'(x >> 20), 12); d.use_imm = 1'b1; d.wr = 1'b1; d.use1 = 1'b1;
            end
            7'h33: begin
                d.op = alu_map[f3];
                if (x[30] && f3 == 0) d.op = 4'd1;
                if (x[30] && f3 == 5) d.op = 4'd7;
                d.wr = 1'b1; d.use1 = 1'b1; d.use2 = 1'b1;
            end
            default: d.ill = 1'b1;
        endcase
        d.wr   = d.wr   && (x[11:7]  != 5'd0);
        d.use1 = d.use1 && (x[19:15] != 5'd0);
        d.use2 = d.use2 && (x[24:20] != 5'd0);
        return d;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return 32'd0;
        if (bus.wbEnable && bus.wbAddr == r) return bus.wbData;
        return rf;
    endfunction

    function automatic logic raw(input logic used, input logic [4:0] r);
        return used && m_pend[r] && !(bus.wbEnable && bus.wbAddr == r);
    endfunction

    task automatic model_reset();
        m_held = '{valid: 1'b0, op: 4'd0, imm: 32'd0, use_imm: 1'b0, rd: 5'd0, wr: 1'b0,
                   ill: 1'b0, srcf: 32'd0, srcs: 32'd0, pc: 32'd0};
        m_pend = 32'd0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".aluValid"},    32'(bus.aluValid),    32'(m_held.valid));
        chk({tag, ".aluOp"},       32'(bus.aluOp),       32'(m_held.op));
        chk({tag, ".aluSrcF"},     bus.aluSrcF,          m_held.srcf);
        chk({tag, ".aluSrcS"},     bus.aluSrcS,          m_held.srcs);
        chk({tag, ".aluImm"},      bus.aluImm,           m_held.imm);
        chk({tag, ".aluUseImm"},   32'(bus.aluUseImm),   32'(m_held.use_imm));
        chk({tag, ".aluRd"},       32'(bus.aluRd),       32'(m_held.rd));
        chk({tag, ".aluRegWrite"}, 32'(bus.aluRegWrite), 32'(m_held.wr));
        chk({tag, ".aluPc"},       bus.aluPc,            m_held.pc);
        chk({tag, ".aluIllegal"},  32'(bus.aluIllegal),  32'(m_held.ill));
        chk({tag, ".pending"},     dut.pending_q,        m_pend);
    endtask

    // One clock: combinational checks at the falling edge, registered checks just after the rise.
    task automatic cyc(input string tag);
        dec_t        d;
        logic        exp_ready, acc;
        logic [31:0] nxt_pend;
        held_t       nxt;
        @(negedge clk);
        d = model_decode(bus.instData);
        exp_ready = !resetIn && !bus.flush && !(m_held.valid && !bus.aluReady)
                    && !raw(d.use1, bus.instData[19:15]) && !raw(d.use2, bus.instData[24:20])
                    && !(d.wr && m_pend[bus.instData[11:7]]);
        sampled_ready = bus.instReady;
        chk({tag, ".instReady"}, 32'(bus.instReady), 32'(exp_ready));
        chk({tag, ".readAddrF"}, 32'(bus.readAddrF), 32'(bus.instData[19:15]));
        chk({tag, ".readAddrS"}, 32'(bus.readAddrS), 32'(bus.instData[24:20]));
        acc      = bus.instValid && exp_ready;
        nxt      = m_held;
        nxt_pend = m_pend;
        if (bus.wbEnable) nxt_pend[bus.wbAddr] = 1'b0;
        if (bus.flush && m_held.valid && m_held.wr) nxt_pend[m_held.rd] = 1'b0;
        if (acc && d.wr) nxt_pend[bus.instData[11:7]] = 1'b1;
        nxt_pend[0] = 1'b0;
        if (acc) begin
            nxt = '{valid: 1'b1, op: d.op, imm: d.imm, use_imm: d.use_imm, rd: bus.instData[11:7],
                    wr: d.wr, ill: d.ill, srcf: operand(bus.instData[19:15], bus.outDataF),
                    srcs: operand(bus.instData[24:20], bus.outDataS), pc: bus.pcIn};
        end else if (bus.aluReady || bus.flush) begin
            nxt.valid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (resetIn) begin
            model_reset();
        end else begin
            m_held = nxt;
            m_pend = nxt_pend;
        end
        check_outputs(tag);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0]  opcs [10];
        logic [31:0] r;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
        r = $urandom;
        r[6:0]   = opcs[$urandom_range(0, 9)];
        r[11:7]  = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    initial begin
        clk = 1'b0;
        resetIn = 1'b1;
        bus.instValid = 1'b0; bus.instData = 32'd0; bus.pcIn = 32'd0;
        bus.outDataF = 32'd0; bus.outDataS = 32'd0;
        bus.wbEnable = 1'b0; bus.wbAddr = 5'd0; bus.wbData = 32'd0;
        bus.flush = 1'b0; bus.aluReady = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        chk("reset.instReady", 32'(bus.instReady), 32'd0);
        cyc("reset_hold");
        cyc("reset_hold");
        resetIn = 1'b0;

        // addi x1,x0,5
        bus.instValid = 1'b1; bus.instData = 32'h00500093; bus.pcIn = 32'h100; bus.aluReady = 1'b1;
        cyc("basic");
        chk("basic.op", 32'(bus.aluOp), 32'd0);
        chk("basic.imm", bus.aluImm, 32'd5);
        chk("basic.useimm", 32'(bus.aluUseImm), 32'd1);
        chk("basic.rd", 32'(bus.aluRd), 32'd1);
        chk("basic.regwrite", 32'(bus.aluRegWrite), 32'd1);
        chk("basic.pend1", 32'(dut.pending_q[1]), 32'd1);

        // add x2,x1,x1 stalls until x1 writes back, then bypasses
        bus.instData = 32'h00108133; bus.pcIn = 32'h104;
        bus.outDataF = 32'hDEAD0001; bus.outDataS = 32'hBEEF0002;
        cyc("raw1");
        chk("raw.stall1", 32'(sampled_ready), 32'd0);
        cyc("raw2");
        chk("raw.stall2", 32'(sampled_ready), 32'd0);
        bus.wbEnable = 1'b1; bus.wbAddr = 5'd1; bus.wbData = 32'd5;
        cyc("raw_wb");
        chk("raw.accept", 32'(sampled_ready), 32'd1);
        chk("raw.srcF", bus.aluSrcF, 32'd5);
        chk("raw.srcS", bus.aluSrcS, 32'd5);
        bus.wbEnable = 1'b0;

        // backpressure: addi x5 held while aluReady low, addi x6 waiting
        bus.instData = 32'h00700293; bus.pcIn = 32'h108;
        cyc("bp_load");
        bus.aluReady = 1'b0; bus.instData = 32'h00900313; bus.pcIn = 32'h10C;
        for (int i = 0; i < 3; i++) begin
            cyc("bp_hold");
            chk("bp.stall", 32'(sampled_ready), 32'd0);
            chk("bp.imm", bus.aluImm, 32'd7);
            chk("bp.rd", 32'(bus.aluRd), 32'd5);
        end
        bus.aluReady = 1'b1;
        cyc("bp_release");
        chk("bp.accept", 32'(sampled_ready), 32'd1);
        chk("bp.newrd", 32'(bus.aluRd), 32'd6);

        // flush while holding addi x3
        bus.instData = 32'h00300193; bus.pcIn = 32'h110;
        cyc("flush_load");
        bus.flush = 1'b1; bus.instData = 32'h00400213; bus.pcIn = 32'h114;
        cyc("flush");
        chk("flush.valid", 32'(bus.aluValid), 32'd0);
        chk("flush.pend3", 32'(dut.pending_q[3]), 32'd0);
        chk("flush.pend4", 32'(dut.pending_q[4]), 32'd0);
        chk("flush.noaccept", 32'(sampled_ready), 32'd0);
        bus.flush = 1'b0;

        // illegal opcode and rd=x0
        pend_before = m_pend;
        bus.instData = 32'hFFFFFFFF; bus.pcIn = 32'h118;
        cyc("illegal");
        chk("illegal.flag", 32'(bus.aluIllegal), 32'd1);
        chk("illegal.regwrite", 32'(bus.aluRegWrite), 32'd0);
        chk("illegal.pending", dut.pending_q, pend_before);
        bus.instData = 32'h00100013; bus.pcIn = 32'h11C;
        cyc("x0");
        chk("x0.regwrite", 32'(bus.aluRegWrite), 32'd0);
        chk("x0.pending", dut.pending_q, pend_before);

        // reset mid-stream with a held instruction
        resetIn = 1'b1;
        #1;
        model_reset();
        chk("midrst.valid", 32'(bus.aluValid), 32'd0);
        chk("midrst.pending", dut.pending_q, 32'd0);
        chk("midrst.instReady", 32'(bus.instReady), 32'd0);
        check_outputs("midrst");
        cyc("midrst_hold");
        cyc("midrst_hold");
        resetIn = 1'b0;

        for (int i = 0; i < 600; i++) begin
            bus.instValid = ($urandom_range(0, 3) != 0);
            bus.instData  = rand_inst();
            bus.pcIn      = $urandom;
            bus.outDataF  = $urandom;
            bus.outDataS  = $urandom;
            bus.wbEnable  = ($urandom_range(0, 1) == 1);
            bus.wbAddr    = 5'($urandom_range(0, 7));
            bus.wbData    = $urandom;
            bus.aluReady  = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
            cyc("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
